// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing with pixel-clock divider and registered sync/blank decode.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_tick,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       line_start,
  output logic       frame_start
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_V    = 10'(H_VIS);
  localparam logic [9:0] V_V    = 10'(V_VIS);
  localparam logic [9:0] HS_ON  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_VIS + V_FP + V_SYNC);
  logic [DW-1:0] div_cnt, div_nxt;
  logic [9:0]    h_cnt, v_cnt, h_nxt, v_nxt;
  logic          h_wrap;
  assign pix_tick = en && (div_cnt == DIV_MAX);
  assign x_pos = h_cnt;
  assign y_pos = v_cnt;
  always_comb begin
    h_wrap  = h_cnt == H_MAX;
    div_nxt = en ? (pix_tick ? '0 : div_cnt + 1'b1) : div_cnt;
    h_nxt   = pix_tick ? (h_wrap ? '0 : h_cnt + 10'd1) : h_cnt;
    v_nxt   = (pix_tick && h_wrap) ? ((v_cnt == V_MAX) ? '0 : v_cnt + 10'd1) : v_cnt;
  end
  // Decode from next counter values so outputs line up with x_pos/y_pos on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      h_cnt       <= H_MAX;
      v_cnt       <= V_MAX;
      valid       <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      valid       <= (h_nxt < H_V) && (v_nxt < V_V);
      hsync       <= (h_nxt >= HS_ON && h_nxt < HS_OFF) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_nxt >= VS_ON && v_nxt < VS_OFF) ? SYNC_POL : ~SYNC_POL;
      line_start  <= h_nxt == '0;
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vector table on the default config plus a scaled CLK_DIV=1/SYNC_POL=1 instance.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n, en, pix_tick, valid, hsync, vsync, line_start, frame_start;
  logic [9:0] x_pos, y_pos;
  logic       rst_s, en_s, pt_s, v_s, hs_s, vs_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;
  int vecs = 0, errs = 0;

  vga_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(pix_tick), .valid(valid),
    .hsync(hsync), .vsync(vsync), .x_pos(x_pos), .y_pos(y_pos),
    .line_start(line_start), .frame_start(frame_start)
  );

  // Scaled geometry: H 8+2+3+3 = 16, V 6+2+2+3 = 13, hsync 10..12, vsync 8..9.
  vga_timing_gen #(
    .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_s), .en(en_s), .pix_tick(pt_s), .valid(v_s),
    .hsync(hs_s), .vsync(vs_s), .x_pos(x_s), .y_pos(y_s),
    .line_start(ls_s), .frame_start(fs_s)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    int         n;
    int         x;
    int         y;
    logic [5:0] f;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic e, int n, int x, int y, logic [5:0] f);
    vec_t t;
    t.rst_n = r; t.en = e; t.n = n; t.x = x; t.y = y; t.f = f;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flags are {valid, hsync, vsync, line_start, frame_start, pix_tick}.
  task automatic check(string nm, logic [9:0] gx, logic [9:0] gy, logic [5:0] gf,
                       int ex, int ey, logic [5:0] ef);
    vecs++;
    if (gx !== 10'(ex) || gy !== 10'(ey) || gf !== ef) begin
      errs++;
      $display("FAIL %s: got x=%0d y=%0d flags=%b, want x=%0d y=%0d flags=%b",
               nm, gx, gy, gf, ex, ey, ef);
    end
  endtask

  task automatic check_int(string nm, int got, int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  function automatic logic [5:0] dflags();
    return {valid, hsync, vsync, line_start, frame_start, pix_tick};
  endfunction

  function automatic logic [5:0] sflags();
    return {v_s, hs_s, vs_s, ls_s, fs_s, pt_s};
  endfunction

  initial begin
    int cnt, nv, nhs, npt, ex, ey;
    logic prev;
    rst_n = 1'b0; en = 1'b1; rst_s = 1'b0; en_s = 1'b1;
    tbl.push_back(mk(0, 1, 5,     799, 524, 6'b011000));
    tbl.push_back(mk(1, 1, 1,     799, 524, 6'b011000));
    tbl.push_back(mk(1, 1, 1,     799, 524, 6'b011000));
    tbl.push_back(mk(1, 1, 1,     799, 524, 6'b011001));
    tbl.push_back(mk(1, 1, 1,     0,   0,   6'b111110));
    tbl.push_back(mk(1, 1, 3,     0,   0,   6'b111111));
    tbl.push_back(mk(1, 1, 1,     1,   0,   6'b111000));
    tbl.push_back(mk(1, 1, 2552,  639, 0,   6'b111000));
    tbl.push_back(mk(1, 1, 4,     640, 0,   6'b011000));
    tbl.push_back(mk(1, 1, 64,    656, 0,   6'b001000));
    tbl.push_back(mk(1, 1, 380,   751, 0,   6'b001000));
    tbl.push_back(mk(1, 1, 4,     752, 0,   6'b011000));
    tbl.push_back(mk(1, 1, 188,   799, 0,   6'b011000));
    tbl.push_back(mk(1, 1, 4,     0,   1,   6'b111100));
    tbl.push_back(mk(1, 1, 28800, 0,   10,  6'b111100));
    tbl.push_back(mk(1, 1, 1200,  300, 10,  6'b111000));
    tbl.push_back(mk(1, 1, 2,     300, 10,  6'b111000));
    tbl.push_back(mk(1, 0, 50,    300, 10,  6'b111000));
    tbl.push_back(mk(1, 1, 1,     300, 10,  6'b111001));
    tbl.push_back(mk(1, 1, 1,     301, 10,  6'b111000));
    tbl.push_back(mk(1, 1, 1596,  700, 10,  6'b001000));
    tbl.push_back(mk(0, 1, 1,     799, 524, 6'b011000));
    tbl.push_back(mk(1, 1, 3,     799, 524, 6'b011001));
    tbl.push_back(mk(1, 1, 1,     0,   0,   6'b111110));
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n;
      en    = tbl[i].en;
      for (int k = 0; k < tbl[i].n; k++) begin
        tick();
        if (!tbl[i].en)
          check($sformatf("hold_row%0d_cyc%0d", i, k), x_pos, y_pos, dflags(),
                tbl[i].x, tbl[i].y, tbl[i].f);
      end
      check($sformatf("row%0d", i), x_pos, y_pos, dflags(), tbl[i].x, tbl[i].y, tbl[i].f);
    end
    // One full line between line_start rising edges.
    prev = line_start;
    cnt = 0;
    while (!(line_start && !prev) && cnt < 4000) begin
      prev = line_start;
      tick();
      cnt++;
    end
    check_int("line_start_found", int'(cnt < 4000), 1);
    cnt = 0; nv = 0; nhs = 0; npt = 0;
    do begin
      nv  += int'(valid);
      nhs += int'(!hsync);
      npt += int'(pix_tick);
      prev = line_start;
      tick();
      cnt++;
    end while (!(line_start && !prev) && cnt < 4000);
    check_int("line_period", cnt, 3200);
    check_int("valid_cycles", nv, 2560);
    check_int("hsync_low_cycles", nhs, 384);
    check_int("pix_tick_count", npt, 800);
    // Scaled instance: reset, two frames against a raster model, enable, mid-frame reset.
    tick();
    tick();
    check("s_reset", x_s, y_s, sflags(), 15, 12, 6'b000001);
    rst_s = 1'b1;
    for (int c = 0; c < 556; c++) begin
      tick();
      ex = c % 16;
      ey = (c / 16) % 13;
      check($sformatf("s_scan%0d", c), x_s, y_s, sflags(), ex, ey,
            {ex < 8 && ey < 6, ex >= 10 && ex < 13, ey >= 8 && ey < 10,
             ex == 0, ex == 0 && ey == 0, 1'b1});
    end
    en_s = 1'b0;
    tick();
    check("s_en_off", x_s, y_s, sflags(), 11, 8, 6'b011000);
    en_s = 1'b1;
    rst_s = 1'b0;
    tick();
    check("s_mid_reset", x_s, y_s, sflags(), 15, 12, 6'b000001);
    rst_s = 1'b1;
    tick();
    check("s_restart", x_s, y_s, sflags(), 0, 0, 6'b100111);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
